// File: rtl/path_select_scheduler.sv
// Time-multiplexed minimum-energy path selector: streams a frame through one N_B-wide select_unit.
// Optional early exit on a good-enough running best: define PATH_SELECT_SCHED_EARLY_EXIT_EN.

module select_unit #(
    parameter int N       = 8,
    parameter int H_DEPTH = 4,
    parameter int EW      = 16
) (
    input  logic [N-1:0][EW-1:0]            energies,
    input  logic [N-1:0][H_DEPTH-1:0][1:0]  histories,
    output logic [EW-1:0]                   min_energy,
    output logic [H_DEPTH-1:0][1:0]         min_history
);
    // NOTE: blocking assignments in always_comb, and both outputs get a default first so no latch is inferred.
    always_comb begin
        min_energy  = energies[0];
        min_history = histories[0];
        for (int i = 1; i < N; i++) begin
            if (energies[i] < min_energy) begin
                min_energy  = energies[i];
                min_history = histories[i];
            end
        end
    end
endmodule

module path_select_scheduler #(
    parameter  int N_TOTAL  = 20,
    parameter  int N_B      = 8,
    parameter  int H_DEPTH  = 4,
    parameter  int B_WIDTH  = 8,
    localparam int EW       = 2 * B_WIDTH,
    localparam int N_CHUNKS = (N_TOTAL + N_B - 1) / N_B,
    localparam int CW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1
) (
    input  logic                                  clk,
    input  logic                                  rstb,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N_TOTAL-1:0][EW-1:0]            path_energies,
    input  logic [N_TOTAL-1:0][H_DEPTH-1:0][1:0]  path_histories,
    output logic                                  out_valid,
    input  logic                                  out_ready,
`ifdef PATH_SELECT_SCHED_EARLY_EXIT_EN
    input  logic [EW-1:0]                         early_exit_thresh,
`endif
    output logic [EW-1:0]                         best_energy,
    output logic [H_DEPTH-1:0][1:0]               best_history,
    output logic [CW-1:0]                         best_chunk
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                                state;
    logic [CW-1:0]                         chunk;
    logic [N_TOTAL-1:0][EW-1:0]            frame_e;
    logic [N_TOTAL-1:0][H_DEPTH-1:0][1:0]  frame_h;

    logic [N_CHUNKS-1:0][N_B-1:0][EW-1:0]           pad_e;
    logic [N_CHUNKS-1:0][N_B-1:0][H_DEPTH-1:0][1:0] pad_h;

    // Slots past the end of the frame carry the worst possible energy so they can never win.
    for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
        for (genvar j = 0; j < N_B; j++) begin : g_slot
            if (c * N_B + j < N_TOTAL) begin : g_real
                assign pad_e[c][j] = frame_e[c * N_B + j];
                assign pad_h[c][j] = frame_h[c * N_B + j];
            end else begin : g_pad
                assign pad_e[c][j] = '1;
                assign pad_h[c][j] = '0;
            end
        end
    end

    logic [EW-1:0]           sel_e;
    logic [H_DEPTH-1:0][1:0] sel_h;

    select_unit #(.N(N_B), .H_DEPTH(H_DEPTH), .EW(EW)) u_select (
        .energies    (pad_e[chunk]),
        .histories   (pad_h[chunk]),
        .min_energy  (sel_e),
        .min_history (sel_h)
    );

    // Strict less-than keeps the earlier chunk on an energy tie.
    logic          take_sel;
    logic [EW-1:0] next_best;
    logic          last_chunk;
    logic          finish_run;

    assign take_sel   = (chunk == '0) || (sel_e < best_energy);
    assign next_best  = take_sel ? sel_e : best_energy;
    assign last_chunk = (chunk == CW'(N_CHUNKS - 1));
`ifdef PATH_SELECT_SCHED_EARLY_EXIT_EN
    assign finish_run = last_chunk || (next_best <= early_exit_thresh);
`else
    assign finish_run = last_chunk;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // NOTE: the frame buffer is reset along with the control state so a post-reset read is deterministic.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            chunk        <= '0;
            frame_e      <= '0;
            frame_h      <= '0;
            best_energy  <= '0;
            best_history <= '0;
            best_chunk   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        frame_e <= path_energies;
                        frame_h <= path_histories;
                        chunk   <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (take_sel) begin
                        best_energy  <= next_best;
                        best_history <= sel_h;
                        best_chunk   <= chunk;
                    end
                    if (finish_run) state <= DONE;
                    else            chunk <= chunk + CW'(1);
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/path_select_scheduler.md
# path_select_scheduler

Time-multiplexed minimum-energy path selector for the Viterbi/MLSD back end. It accepts a full frame of `N_TOTAL` candidate paths and streams them `N_B` at a time through one internally instantiated `select_unit`. Across chunks it tracks the running minimum-energy path and returns the winner over a valid/ready handshake. This lets one narrow selector serve path sets wider than is affordable to reduce in a single combinational cycle.

## Interface
Parameters:
- `N_TOTAL`, 20: candidate paths per frame (≥1).
- `N_B`, 8: paths per chunk, i.e. the width of the internal `select_unit` (1–32).
- `H_DEPTH`, 4: history symbols per path.
- `B_WIDTH`, 8: half the energy width; energies are `2*B_WIDTH` bits, unsigned.
- Derived `N_CHUNKS` = ceil(`N_TOTAL`/`N_B`); `CW` = max(1, clog2(`N_CHUNKS`)).

Ports:
- `clk`  in  1  single clock.
- `rstb`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  frame offered.
- `in_ready`  out  1  block can accept a frame.
- `path_energies`  in  [2*B_WIDTH-1:0] x N_TOTAL  candidate energies.
- `path_histories`  in  signed [1:0] x N_TOTAL x H_DEPTH  candidate histories.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `best_energy`  out  [2*B_WIDTH-1:0]  winning energy.
- `best_history`  out  signed [1:0] x H_DEPTH  winning history.
- `best_chunk`  out  [CW-1:0]  index of the chunk that supplied the winner.
- `early_exit_thresh`  in  [2*B_WIDTH-1:0]  present only with `PATH_SELECT_SCHED_EARLY_EXIT_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE:
  - `in_ready`=1, combinational on the state.
  - On `in_valid & in_ready`, register all energies and histories into a frame buffer, clear the chunk counter, go to RUN.
- RUN, one chunk per cycle:
  - Chunk k drives buffer entries [k*N_B .. k*N_B+N_B-1] into `select_unit`.
  - Slots past `N_TOTAL` are padded with energy all-ones and history 0.
  - Chunk 0 loads the running best unconditionally.
  - Chunk k>0 replaces the running best only if its energy is strictly less. On equal energies the earlier chunk wins.
  - When the replacement happens, `best_chunk` is set to k.
  - After chunk `N_CHUNKS`-1, go to DONE.
- DONE:
  - `out_valid`=1 and outputs are held stable.
  - On `out_valid & out_ready`, go to IDLE.
  - `in_ready` rises the following cycle. No same-cycle re-accept.
- Input changes while not in IDLE are ignored because the frame buffer is private.
- `best_*` registers hold their last value in IDLE.
- Tie order within a chunk is whatever `select_unit` produces. The block guarantees tie order only across chunks.

## Timing
- Reset (async assert, sync release):
  - State=IDLE, so `in_ready`=1.
  - `out_valid`=0, `best_energy`=0, `best_history`=all 0, `best_chunk`=0.
  - Chunk counter=0 and frame buffer=0.
- Latency: with the accept at edge E0, `out_valid` rises after edge E`N_CHUNKS`. That is exactly `N_CHUNKS` cycles, regardless of `out_ready`.
- Throughput: one frame per `N_CHUNKS`+2 cycles when `out_ready` is held high.
- The chunk counter never wraps; it is cleared on accept.
- `rstb` asserted mid-RUN or mid-DONE aborts immediately. The result is discarded and no `out_valid` pulse occurs.
- `N_TOTAL`≤`N_B` degenerates to `N_CHUNKS`=1, giving a single RUN cycle.

## Configuration
- `PATH_SELECT_SCHED_EARLY_EXIT_EN` defined:
  - Adds the port `early_exit_thresh`.
  - In RUN, after the running best is updated for chunk k, if running best ≤ `early_exit_thresh`, go to DONE immediately. Remaining chunks are skipped.
  - Latency becomes k+1 cycles.
  - A threshold of 0 exits early only on a zero-energy winner.
- Undefined: the port is absent and every frame always takes `N_CHUNKS` cycles.

## Test plan
Default parameters: `N_TOTAL`=20, `N_B`=8, 3 chunks.
- Basic frame: energies 100+i, except index 13 = 5 with history {1,-1,0,1} → `out_valid` 3 cycles after accept; `best_energy`=5, `best_history`={1,-1,0,1}, `best_chunk`=1.
- Padding: all energies 0xFFFE, index 19 = 0xFFF0 → `best_energy`=0xFFF0, `best_chunk`=2. Padded all-ones slots never win.
- Cross-chunk tie: index 2 = 7 and index 9 = 7, all others 50 → `best_chunk`=0, index-2 history returned.
- Backpressure: hold `out_ready`=0 for 5 cycles → outputs stable, `in_ready`=0, a new `in_valid` is ignored. Release → IDLE and `in_ready`=1 next cycle.
- Reset mid-RUN: drop `rstb` one cycle after accept → `out_valid`=0, all outputs 0, `in_ready`=1. No result emitted after release.
- With `PATH_SELECT_SCHED_EARLY_EXIT_EN`: threshold=10, index 3 = 4 → `out_valid` 1 cycle after accept, `best_chunk`=0. Threshold=3 → full 3-cycle latency, same winner.
